// File: rtl/booth_ctrl_pkg.sv
// Shared definitions for the radix-2 Booth multiplier controller.
//   - state_t   : FSM state encoding (3-bit binary)
//   - PAIR_SUB  : {Q[0],Q-1} pair that selects A-M
//   - PAIR_ADD  : {Q[0],Q-1} pair that selects A+M
package booth_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        TEST  = 3'd2,
        ADD   = 3'd3,
        SUB   = 3'd4,
        SHIFT = 3'd5,
        DONE  = 3'd6
    } state_t;

    localparam logic [1:0] PAIR_SUB = 2'b10;
    localparam logic [1:0] PAIR_ADD = 2'b01;

endpackage

// File: rtl/booth_ctrl_iter_cnt.sv
// Iteration counter for the Booth controller.
// Ports:
//   clk   in   system clock
//   reset in   synchronous active-high reset, clears the count
//   clr   in   synchronous clear (operation start)
//   inc   in   advance by one (one per shift)
//   last  out  count has reached N-1, i.e. the current shift is the final one
module booth_ctrl_iter_cnt #(
    parameter int N  = 4,
    parameter int CW = $clog2(N + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic last
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CW'(N))) begin
            // Saturate at N so the count can never wrap back into range.
            cnt <= cnt + 1'b1;
        end
    end

    assign last = (cnt == CW'(N - 1));

endmodule

// File: rtl/booth_ctrl.sv
// Control unit for an N-bit radix-2 Booth shift-add multiplier.
// Sequences the A accumulator, Q multiplier, Q-1 bit and M multiplicand
// registers of the datapath. Outputs are Moore (decoded from state only).
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | clear A, load Q and M, clear Q-1, reset iteration count
// TEST  | inspect {q0,qm1} to choose add, subtract or shift only
// ADD   | A <= A + M
// SUB   | A <= A - M
// SHIFT | arithmetic shift right of {A,Q,Q-1}, count one iteration
// DONE  | result valid; wait for start to drop
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start               level request, sampled in IDLE/DONE only
//   q0, qm1             datapath Q[0] and Q-1
//   ClrA, CargaA        clear A / load A from the adder
//   DesplazaA           arithmetic shift right of A
//   CargaQ, DesplazaQ   load Q (and clear Q-1) / shift Q
//   CargaM              load M
//   Resta               adder mode, 1 = A-M
//   fin                 product {A,Q} valid
module booth_ctrl
    import booth_ctrl_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = $clog2(N + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic q0,
    input  logic qm1,
    output logic ClrA,
    output logic CargaA,
    output logic DesplazaA,
    output logic CargaQ,
    output logic DesplazaQ,
    output logic CargaM,
    output logic Resta,
    output logic fin
);

    state_t state;
    state_t state_next;
    logic   cnt_last;

    booth_ctrl_iter_cnt #(
        .N  (N),
        .CW (CW)
    ) u_iter_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (state == LOAD),
        .inc   (state == SHIFT),
        .last  (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ClrA       = 1'b0;
        CargaA     = 1'b0;
        DesplazaA  = 1'b0;
        CargaQ     = 1'b0;
        DesplazaQ  = 1'b0;
        CargaM     = 1'b0;
        Resta      = 1'b0;
        fin        = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                ClrA       = 1'b1;
                CargaQ     = 1'b1;
                CargaM     = 1'b1;
                state_next = TEST;
            end
            TEST: begin
                case ({q0, qm1})
                    PAIR_SUB: state_next = SUB;
                    PAIR_ADD: state_next = ADD;
                    default:  state_next = SHIFT;
                endcase
            end
            ADD: begin
                CargaA     = 1'b1;
                state_next = SHIFT;
            end
            SUB: begin
                CargaA     = 1'b1;
                Resta      = 1'b1;
                state_next = SHIFT;
            end
            SHIFT: begin
                DesplazaA  = 1'b1;
                DesplazaQ  = 1'b1;
                state_next = cnt_last ? DONE : TEST;
            end
            DONE: begin
                fin = 1'b1;
                // Holding start keeps us here; a new operation needs a fresh rise.
                if (!start) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_booth_ctrl.sv
// Scoreboard bench for booth_ctrl. Models the A/Q/Q-1/M datapath so q0/qm1
// follow the issued control pulses; expected control words and products are
// queued by the stimulus and checked by an independent monitor.
module tb_booth_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic q0, qm1;
    logic ClrA, CargaA, DesplazaA, CargaQ, DesplazaQ, CargaM, Resta, fin;

    int n_checks = 0;
    int n_fail   = 0;

    // control word: {ClrA,CargaA,DesplazaA,CargaQ,DesplazaQ,CargaM,Resta,fin}
    localparam logic [7:0] W_LOAD  = 8'b1001_0100;
    localparam logic [7:0] W_ADD   = 8'b0100_0000;
    localparam logic [7:0] W_SUB   = 8'b0100_0010;
    localparam logic [7:0] W_SHIFT = 8'b0010_1000;
    localparam logic [7:0] W_FIN   = 8'b0000_0001;

    logic [7:0] exp_q[$];
    logic [7:0] prod_q[$];

    logic [3:0] ma, mq, mm;
    logic       mqm1;
    logic [3:0] op_q, op_m;
    logic [7:0] word;
    logic       fin_prev = 1'b0;

    assign word = {ClrA, CargaA, DesplazaA, CargaQ, DesplazaQ, CargaM, Resta, fin};
    assign q0   = mq[0];
    assign qm1  = mqm1;

    always #5 clk = ~clk;

    booth_ctrl #(.N(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .q0        (q0),
        .qm1       (qm1),
        .ClrA      (ClrA),
        .CargaA    (CargaA),
        .DesplazaA (DesplazaA),
        .CargaQ    (CargaQ),
        .DesplazaQ (DesplazaQ),
        .CargaM    (CargaM),
        .Resta     (Resta),
        .fin       (fin)
    );

    // Datapath model.
    initial begin
        ma = '0; mq = '0; mm = '0; mqm1 = 1'b0;
    end
    always @(posedge clk) begin
        if (ClrA)           ma <= '0;
        else if (CargaA)    ma <= Resta ? (ma - mm) : (ma + mm);
        else if (DesplazaA) ma <= {ma[3], ma[3:1]};
        if (CargaQ) begin
            mq   <= op_q;
            mqm1 <= 1'b0;
        end else if (DesplazaQ) begin
            mq   <= {ma[0], mq[3:1]};
            mqm1 <= mq[0];
        end
        if (CargaM) mm <= op_m;
    end

    // Monitor: invariants every cycle, scoreboard on every active output.
    always @(negedge clk) begin
        logic [7:0] e;
        n_checks++;
        if ((CargaA && DesplazaA) || (DesplazaA != DesplazaQ) ||
            ($countones({fin, CargaA, DesplazaA}) > 1)) begin
            n_fail++;
            $display("FAIL invariant word=%b at %0t", word, $time);
        end
        if (word != 8'h00) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL ctrl_word got %b with nothing expected at %0t", word, $time);
            end else begin
                e = exp_q.pop_front();
                if (word != e) begin
                    n_fail++;
                    $display("FAIL ctrl_word got %b exp %b at %0t", word, e, $time);
                end
            end
        end
        if (fin && !fin_prev) begin
            n_checks++;
            if (prod_q.size() == 0) begin
                n_fail++;
                $display("FAIL product got %h with nothing expected", {ma, mq});
            end else begin
                e = prod_q.pop_front();
                if ({ma, mq} != e) begin
                    n_fail++;
                    $display("FAIL product got %h exp %h", {ma, mq}, e);
                end
            end
        end
        fin_prev <= fin;
    end

    // ops: 2 bits per iteration, iteration 0 in [1:0]; 0 = shift only, 1 = ADD, 2 = SUB
    task automatic push_seq(input logic [7:0] ops, input int n_shift, input int fin_cycles);
        logic [1:0] op;
        exp_q.push_back(W_LOAD);
        for (int i = 0; i < n_shift; i++) begin
            op = ops[2*i +: 2];
            if (op == 2'd1) exp_q.push_back(W_ADD);
            if (op == 2'd2) exp_q.push_back(W_SUB);
            exp_q.push_back(W_SHIFT);
        end
        for (int i = 0; i < fin_cycles; i++) exp_q.push_back(W_FIN);
    endtask

    // Counts posedges after the sampling edge until fin is seen.
    task automatic wait_fin(input string name, input int exp_lat);
        int lat;
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (fin) begin
                lat = c;
                break;
            end
        end
        n_checks++;
        if (lat != exp_lat) begin
            n_fail++;
            $display("FAIL %s latency got %0d exp %0d", name, lat, exp_lat);
        end
    endtask

    task automatic run_op(input string name, input logic [3:0] q, input logic [3:0] m,
                          input logic [7:0] ops, input int exp_lat, input logic [7:0] prod,
                          input int hold);
        op_q = q;
        op_m = m;
        push_seq(ops, 4, (hold == 0) ? 1 : hold);
        prod_q.push_back(prod);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (hold == 0) start = 1'b0;
        wait_fin(name, exp_lat);
        if (hold != 0) begin
            repeat (hold) @(negedge clk);
            start = 1'b0;
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int shifts;
        op_q = 4'b0000;
        op_m = 4'b0011;

        // Reset held with start high: nothing may come out.
        reset = 1'b1;
        start = 1'b1;
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if (word != 8'h00) begin
                n_fail++;
                $display("FAIL reset_outputs got %b exp 00000000", word);
            end
        end
        push_seq(8'b00_00_00_00, 4, 1);
        prod_q.push_back(8'h00);
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (word != W_LOAD) begin
            n_fail++;
            $display("FAIL load_after_reset got %b exp %b", word, W_LOAD);
        end
        start = 1'b0;
        wait_fin("q0000_after_reset", 9);
        repeat (3) @(negedge clk);

        run_op("q0000", 4'b0000, 4'b0011, 8'b00_00_00_00, 9,  8'h00, 0);
        run_op("q0101", 4'b0101, 4'b0011, 8'b01_10_01_10, 13, 8'h0F, 0);
        run_op("q1111", 4'b1111, 4'b0011, 8'b00_00_00_10, 10, 8'hFD, 0);

        // Abort during the third shift.
        op_q = 4'b0101;
        op_m = 4'b0011;
        push_seq(8'b01_10_01_10, 3, 0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        shifts = 0;
        for (int c = 0; c < 40 && shifts < 3; c++) begin
            @(negedge clk);
            if (DesplazaA) shifts++;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (word != 8'h00 || shifts != 3) begin
            n_fail++;
            $display("FAIL mid_reset got %b shifts %0d exp 00000000 shifts 3", word, shifts);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL mid_reset_leftover got %0d exp 0", exp_q.size());
        end

        run_op("q0101_after_abort", 4'b0101, 4'b0011, 8'b01_10_01_10, 13, 8'h0F, 0);

        // Start held through DONE: fin stays, no relaunch; then a fresh start.
        run_op("q0101_held", 4'b0101, 4'b0011, 8'b01_10_01_10, 13, 8'h0F, 5);
        run_op("q1111_restart", 4'b1111, 4'b0101, 8'b00_00_00_10, 10, 8'hFB, 0);

        repeat (4) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0 || prod_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover got %0d/%0d exp 0/0", exp_q.size(), prod_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
